// File: rtl/regfile_pkg.sv
// Shared constants and bus-packing helpers for the register file and its scoreboard.
package regfile_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned ZERO_IDX   = 0;

    // Lowest bit of lane idx in a flattened bus of w-bit lanes.
    function automatic int unsigned lane_lo(input int unsigned idx, input int unsigned w);
        return idx * w;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits, reservation acceptance and busy-register counter.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic                    rsv_en,
    input  logic [ADDR_W-1:0]       rsv_addr,
    output logic                    rsv_ok,
    output logic [(2**ADDR_W)-1:0]  busy,
    output logic [ADDR_W:0]         busy_cnt
);

    localparam int unsigned DEPTH = 2**ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic             rsv_zero;
    logic             clr;
    logic [DEPTH-1:0] busy_nxt;

    assign rsv_zero = (ZERO_REG != 0) && (rsv_addr == ADDR_W'(ZERO_IDX));
    assign rsv_ok   = rsv_en & ~rst & ~busy[rsv_addr] & ~rsv_zero;
    // A write retires a reservation only if the bit was set before the edge.
    assign clr      = wr_en & busy[wr_addr];

    // Reservation is applied after the write clear so it wins on a shared address.
    always_comb begin
        busy_nxt = busy;
        if (wr_en) begin
            busy_nxt[wr_addr] = 1'b0;
        end
        if (rsv_ok) begin
            busy_nxt[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= busy_cnt + CNT_W'(rsv_ok) - CNT_W'(clr);
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Parametrised multi-read register file with busy scoreboard and watch port.
// Optional same-cycle write-to-read forwarding: define REGFILE_BYPASS_EN.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned NUM_RD    = 2,
    parameter int unsigned ZERO_REG  = 1,
    parameter int unsigned WATCH_REG = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rsv_en,
    input  logic [ADDR_W-1:0]          rsv_addr,
    output logic                       rsv_ok,
    output logic [ADDR_W:0]            busy_cnt,
    output logic [DATA_W-1:0]          watch_data
);

    localparam int unsigned DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic              wr_eff;
    logic              wr_live;

    // Writes to the hardwired zero register never reach storage or the scoreboard.
    assign wr_eff  = wr_en & ~((ZERO_REG != 0) && (wr_addr == ADDR_W'(ZERO_IDX)));
    assign wr_live = wr_eff & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else if (wr_eff) begin
            mem[wr_addr] <= wr_data;
        end
    end

    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_eff),
        .wr_addr  (wr_addr),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .rsv_ok   (rsv_ok),
        .busy     (busy),
        .busy_cnt (busy_cnt)
    );

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic              zero_hit;
        logic              byp;

        assign a        = rd_addr[lane_lo(i, ADDR_W) +: ADDR_W];
        assign zero_hit = (ZERO_REG != 0) && (a == ADDR_W'(ZERO_IDX));
`ifdef REGFILE_BYPASS_EN
        assign byp      = wr_live && (wr_addr == a);
`else
        assign byp      = 1'b0;
`endif
        assign rd_data[lane_lo(i, DATA_W) +: DATA_W] =
            zero_hit ? '0 : (byp ? wr_data : mem[a]);
        assign rd_busy[i] = ~zero_hit & ~byp & busy[a];
    end

`ifdef REGFILE_BYPASS_EN
    assign watch_data = (wr_live && (wr_addr == ADDR_W'(WATCH_REG))) ? wr_data
                                                                     : mem[ADDR_W'(WATCH_REG)];
`else
    assign watch_data = mem[ADDR_W'(WATCH_REG)];
`endif

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised successor to the single-write, dual-read processor register file.
- Generalised widths and read-port count.
- Adds async reset clearing, optional hardwired zero register, and a watch port for board LEDs/debug.
- Adds a per-register busy scoreboard so multi-cycle units can reserve a destination and the decode stage can detect hazards.
- Sits between decode (reads, reserve) and writeback (write) in the soft processor.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; depth = 2**ADDR_W
NUM_RD, 2, number of independent read ports (1..4)
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, can never be busy
WATCH_REG, 12, index driven onto watch_data

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
rd_addr  in  NUM_RD*ADDR_W  packed read addresses, port i at [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  packed read data, same packing
rd_busy  out  NUM_RD  busy flag of each addressed register
wr_en  in  1  writeback strobe
wr_addr  in  ADDR_W  writeback destination
wr_data  in  DATA_W  writeback value
rsv_en  in  1  reservation request
rsv_addr  in  ADDR_W  register to mark busy
rsv_ok  out  1  reservation accepted this cycle
busy_cnt  out  ADDR_W+1  number of registers currently busy
watch_data  out  DATA_W  current contents of WATCH_REG

Behaviour:
Clock and reset (already decided): one clock, clk; reset is asynchronous and active-high, rst.

Reset:
- All registers are 0, all busy bits are 0, busy_cnt = 0.
- rd_data, rd_busy and watch_data reflect the cleared state combinationally.
- rsv_ok = 0 while rst is high.
- Reset mid-reservation or mid-write discards the pending operation.

Reads:
- Combinational, zero latency.
- rd_data[i] = mem[rd_addr[i]].
- With ZERO_REG = 1 and address 0: data is 0 and busy is 0.
- rd_busy[i] = busy[rd_addr[i]].

Write:
- At posedge clk, if wr_en: mem[wr_addr] <= wr_data and busy[wr_addr] <= 0.
- Writes to register 0 are dropped when ZERO_REG = 1.
- Writing a non-busy register is legal; the busy bit stays 0.

Reserve:
- rsv_ok = rsv_en & ~rst & ~busy[rsv_addr] & ~(ZERO_REG & rsv_addr == 0).
- If rsv_ok, busy[rsv_addr] <= 1 at posedge.
- A rejected request (already busy) changes nothing; the requester retries.

Same-cycle write and reserve to the same address:
- Data is written and busy ends at 1, because the new reservation wins.
- rsv_ok evaluates the pre-edge busy bit.
  - If the register was busy, rsv_ok = 0.
  - The write then clears it, so busy ends at 0.
  - The requester retries the next cycle.

busy_cnt:
- Registered, updated each posedge by +1 for an accepted reserve that sets a bit.
- Updated by -1 for a write that clears a set bit.
- Net 0 when both apply to different registers, or when both apply to the same register.
- Never wraps; the maximum is 2**ADDR_W - ZERO_REG.

watch_data:
- Combinational view of mem[WATCH_REG].

Optional Feature:
REGFILE_BYPASS_EN
- Defined:
  - A read port whose address matches wr_addr while wr_en is high returns wr_data in the same cycle.
  - Its rd_busy is 0 for that cycle.
  - Register 0 is excluded when ZERO_REG = 1.
  - watch_data is also bypassed.
- Undefined:
  - Reads return stored contents only; new data is visible the cycle after the write edge.
  - rd_busy shows the stored busy bit.

Decomposition:
- Shared package regfile_pkg: DATA_W/ADDR_W defaults, the zero-register index constant, and the pack/unpack index helpers for the flattened port buses.
- One natural sub-module, rf_scoreboard: busy bit vector, rsv_ok logic and busy_cnt counter, instantiated by regfile_scoreboard next to the storage array.

Test Plan:
- Reset: assert rst mid-run after writing r5 = 0xDEADBEEF and reserving r7 -> all rd_data = 0, rd_busy = 0, busy_cnt = 0 immediately, without waiting for a clock edge.
- Write/read: write r9 = 0x10, then r12 = 0x55 -> next cycle port0 at r9 reads 0x10; watch_data = 0x55; with ZERO_REG = 1, a write of 0xFFFF to r0 leaves port1 at r0 reading 0.
- Scoreboard: reserve r3 (rsv_ok = 1) -> rd_busy = 1 and busy_cnt = 1; reserve r3 again -> rsv_ok = 0 and busy_cnt stays 1; write r3 = 0x42 -> busy clears, busy_cnt = 0.
- Simultaneous events on the same address:
  - Free r4, reserve and write together -> r4 = data, busy = 1, busy_cnt = 1.
  - Busy r4, reserve and write together -> rsv_ok = 0, busy = 0, busy_cnt decrements.
- Counter on different addresses: reserve r6 while writing busy r3 in the same cycle -> busy_cnt unchanged; fill all 31 registers -> busy_cnt = 31, and further reserves are rejected.
- Bypass: write r10 = 0xABCD with port0 at r10 in the same cycle -> 0xABCD with REGFILE_BYPASS_EN, the old value without it; the next cycle reads 0xABCD in both builds.
